// File: rtl/maze_pkg.sv
// Shared maze geometry, tile coordinate type and address helpers for the
// maze tile RAM (15 rows x 20 columns, 1 bit per tile, 1 = wall).
package maze_pkg;

    localparam int MAZE_ROWS   = 15;
    localparam int MAZE_COLS   = 20;
    localparam int TILE_SHIFT  = 5;
    localparam int MAZE_ADDR_W = 9;

    typedef struct packed {
        logic [3:0]            row;
        logic [TILE_SHIFT-1:0] col;
    } tile_coord_t;

    // row*20 + col built from shifts; in-range results top out at 299.
    function automatic logic [MAZE_ADDR_W-1:0] tile_addr(input tile_coord_t c);
        logic [MAZE_ADDR_W-1:0] r;
        logic [MAZE_ADDR_W-1:0] k;
        r = {{(MAZE_ADDR_W-4){1'b0}}, c.row};
        k = {{(MAZE_ADDR_W-TILE_SHIFT){1'b0}}, c.col};
        return (r << 4) + (r << 2) + k;
    endfunction

    function automatic logic tile_oor(input tile_coord_t c);
        return (c.row >= 4'(MAZE_ROWS)) || (c.col >= TILE_SHIFT'(MAZE_COLS));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after the
// pointer wins, and the next pointer lands just past the winner.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_elig,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_next_ptr
);

    localparam logic [PTR_W:0] N_W = (PTR_W+1)'(N);
    localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [PTR_W-1:0] w_off;
    logic [PTR_W:0]   w_sum;
    logic [PTR_W:0]   w_idx;
    logic [PTR_W:0]   w_nxt;

    // Rotating a doubled copy makes the pointer position bit 0, so the
    // lowest set bit of the window is the round-robin winner.
    always_comb begin
        w_dbl = {i_elig, i_elig};
        w_rot = w_dbl[{1'b0, i_ptr} +: N];
        w_off = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (w_rot[k]) w_off = PTR_W'(k);
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        w_idx = (w_sum >= N_W) ? (w_sum - N_W) : w_sum;
        w_nxt = ((w_idx + ONE) >= N_W) ? '0 : (w_idx + ONE);

        o_grant    = '0;
        o_next_ptr = i_ptr;
        if (|i_elig) begin
            o_grant[w_idx[PTR_W-1:0]] = 1'b1;
            o_next_ptr                = w_nxt[PTR_W-1:0];
        end
    end

endmodule

// File: rtl/maze_port_arbiter.sv
// Shares the single-port maze tile RAM among NUM_REQ requesters: round-robin
// grant, coordinate-to-address conversion, and a one-cycle ack two edges later.
module maze_port_arbiter
    import maze_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     we,
    input  logic [NUM_REQ*4-1:0]   row,
    input  logic [NUM_REQ*5-1:0]   col,
    input  logic [NUM_REQ-1:0]     wdata,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   rdata,
    output logic                   busy,
    output logic [MAZE_ADDR_W-1:0] ram_addr,
    output logic                   ram_rd,
    output logic                   ram_we,
    output logic                   ram_wdata,
    input  logic                   ram_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]       r_ptr;
    logic [NUM_REQ-1:0]     r_pending;

    logic [NUM_REQ-1:0]     w_elig;
    logic [NUM_REQ-1:0]     w_grant;
    logic [NUM_REQ-1:0]     w_ack_set;
    logic [NUM_REQ-1:0]     w_pending_nxt;
    logic [IDX_W-1:0]       w_ptr_nxt;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_any;
    logic                   w_we;
    logic                   w_wdata;
    logic                   w_oor;
    tile_coord_t            w_coord;
    logic [MAZE_ADDR_W-1:0] w_addr;

    logic                   r_vld_p0;
    logic [IDX_W-1:0]       r_idx_p0;
    logic                   r_rd_p0;
    logic                   r_oor_p0;
    logic                   r_vld_p1;
    logic [IDX_W-1:0]       r_idx_p1;
    logic                   r_rd_p1;
    logic                   r_oor_p1;

    // A requester sitting in its ack cycle is excluded so a held req cannot
    // be granted twice before the requester has seen the ack.
    assign w_elig = req & ~r_pending & ~ack;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (IDX_W)
    ) u_rr (
        .i_elig     (w_elig),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_ptr_nxt)
    );

    always_comb begin
        w_idx   = '0;
        w_we    = 1'b0;
        w_wdata = 1'b0;
        w_coord = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_idx       = IDX_W'(i);
                w_we        = we[i];
                w_wdata     = wdata[i];
                w_coord.row = row[4*i +: 4];
                w_coord.col = col[5*i +: 5];
            end
        end
    end

    assign w_any         = |w_grant;
    assign w_oor         = tile_oor(w_coord);
    assign w_addr        = tile_addr(w_coord);
    assign w_ack_set     = r_vld_p1 ? (NUM_REQ'(1) << r_idx_p1) : '0;
    assign w_pending_nxt = (r_pending & ~w_ack_set) | w_grant;

    // Stage p0: grant edge -- RAM strobes, address and transaction tag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr     <= '0;
            r_pending <= '0;
            busy      <= 1'b0;
            r_vld_p0  <= 1'b0;
            ram_addr  <= '0;
            ram_rd    <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_pending <= w_pending_nxt;
            busy      <= |w_pending_nxt;
            r_vld_p0  <= w_any;
            ram_rd    <= w_any & ~w_we & ~w_oor;
            ram_we    <= w_any &  w_we & ~w_oor;
            if (w_any) begin
                ram_addr  <= w_addr;
                ram_wdata <= w_wdata;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_any) begin
            r_idx_p0 <= w_idx;
            r_rd_p0  <= ~w_we;
            r_oor_p0 <= w_oor;
        end
    end

    // Stage p1: the RAM samples the access on this edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= r_vld_p0;
        end
    end

    always_ff @(posedge Clk) begin
        r_idx_p1 <= r_idx_p0;
        r_rd_p1  <= r_rd_p0;
        r_oor_p1 <= r_oor_p0;
    end

    // Stage p2: response -- off-map reads look like walls, writes return 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ack   <= '0;
            rdata <= 1'b0;
        end else begin
            ack   <= w_ack_set;
            rdata <= r_vld_p1 & r_rd_p1 & (r_oor_p1 | ram_rdata);
        end
    end

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed bench for maze_port_arbiter with a behavioural synchronous tile RAM.
module tb_maze_port_arbiter;

    logic         Clk;
    logic         Reset_n;
    logic [3:0]   req;
    logic [3:0]   we;
    logic [15:0]  row;
    logic [19:0]  col;
    logic [3:0]   wdata;
    logic [3:0]   ack;
    logic         rdata;
    logic         busy;
    logic [8:0]   ram_addr;
    logic         ram_rd;
    logic         ram_we;
    logic         ram_wdata;
    logic         ram_rdata;

    logic         mem [512];

    int errors = 0;
    int checks = 0;

    maze_port_arbiter #(.NUM_REQ(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
        .we        (we),
        .row       (row),
        .col       (col),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Tile RAM model: initial contents are addr[0], so odd addresses are walls.
    initial begin
        for (int a = 0; a < 512; a++) mem[a] = a[0];
    end

    always @(posedge Clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [3:0] r,
                           input logic [4:0] c, input logic d);
        we[i]         = w;
        row[4*i +: 4] = r;
        col[5*i +: 5] = c;
        wdata[i]      = d;
        req[i]        = 1'b1;
    endtask

    task automatic apply_reset();
        Reset_n = 1'b0;
        req     = '0;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        req = '0; we = '0; row = '0; col = '0; wdata = '0;
        tick();
        tick();
        checks++; if ({ack, rdata, busy} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=000000", {ack, rdata, busy}); end
        checks++; if ({ram_addr, ram_rd, ram_we, ram_wdata} !== 12'b0) begin errors++; $display("FAIL reset_ram got=%h exp=000", {ram_addr, ram_rd, ram_we, ram_wdata}); end
        req = 4'hF;
        tick();
        checks++; if ({ram_rd, busy} !== 2'b00) begin errors++; $display("FAIL reset_no_grant got=%b exp=00", {ram_rd, busy}); end
        req = '0;
        Reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        apply_reset();
        set_req(1, 1'b0, 4'd2, 5'd3, 1'b0);
        tick();
        checks++; if (ram_rd !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL single_strobe got rd=%b we=%b exp rd=1 we=0", ram_rd, ram_we); end
        checks++; if (ram_addr !== 9'd43) begin errors++; $display("FAIL single_addr got=%0d exp=43", ram_addr); end
        checks++; if (busy !== 1'b1 || ack !== 4'b0) begin errors++; $display("FAIL single_busy got busy=%b ack=%b exp busy=1 ack=0000", busy, ack); end
        tick();
        checks++; if (ram_rd !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL single_e1 got rd=%b ack=%b exp rd=0 ack=0000", ram_rd, ack); end
        tick();
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL single_ack got=%b exp=0010", ack); end
        checks++; if (rdata !== 1'b1) begin errors++; $display("FAIL single_rdata got=%b exp=1", rdata); end
        req[1] = 1'b0;
        tick();
        checks++; if (ack !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done got ack=%b busy=%b exp ack=0000 busy=0", ack, busy); end
    endtask

    task automatic test_all_four();
        logic [8:0] exp_addr [4];
        logic       exp_bit  [4];
        logic [3:0] exp_ack;
        exp_addr[0] = 9'd20;  exp_bit[0] = 1'b0;
        exp_addr[1] = 9'd43;  exp_bit[1] = 1'b1;
        exp_addr[2] = 9'd299; exp_bit[2] = 1'b1;
        exp_addr[3] = 9'd5;   exp_bit[3] = 1'b1;
        apply_reset();
        set_req(0, 1'b0, 4'd1,  5'd0,  1'b0);
        set_req(1, 1'b0, 4'd2,  5'd3,  1'b0);
        set_req(2, 1'b0, 4'd14, 5'd19, 1'b0);
        set_req(3, 1'b0, 4'd0,  5'd5,  1'b0);
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n <= 4) begin
                checks++; if (ram_rd !== 1'b1 || ram_addr !== exp_addr[n-1]) begin errors++; $display("FAIL all4_grant cyc=%0d got rd=%b addr=%0d exp rd=1 addr=%0d", n, ram_rd, ram_addr, exp_addr[n-1]); end
            end else begin
                checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL all4_idle cyc=%0d got rd=%b exp=0", n, ram_rd); end
            end
            exp_ack = (n >= 3) ? (4'b0001 << (n-3)) : 4'b0000;
            checks++; if (ack !== exp_ack) begin errors++; $display("FAIL all4_ack cyc=%0d got=%b exp=%b", n, ack, exp_ack); end
            checks++; if (busy !== (n < 6)) begin errors++; $display("FAIL all4_busy cyc=%0d got=%b exp=%b", n, busy, (n < 6)); end
            if (n >= 3) begin
                checks++; if (rdata !== exp_bit[n-3]) begin errors++; $display("FAIL all4_rdata cyc=%0d got=%b exp=%b", n, rdata, exp_bit[n-3]); end
                req[n-3] = 1'b0;
            end
        end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        set_req(0, 1'b0, 4'd15, 5'd0, 1'b0);
        tick();
        checks++; if (ram_rd !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL oor_rd_strobe got rd=%b we=%b exp 0 0", ram_rd, ram_we); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL oor_rd_busy got=%b exp=1", busy); end
        tick();
        tick();
        checks++; if (ack !== 4'b0001 || rdata !== 1'b1) begin errors++; $display("FAIL oor_rd_ack got ack=%b rdata=%b exp ack=0001 rdata=1", ack, rdata); end
        req[0] = 1'b0;
        set_req(1, 1'b1, 4'd0, 5'd20, 1'b1);
        tick();
        checks++; if (ram_we !== 1'b0 || ram_rd !== 1'b0) begin errors++; $display("FAIL oor_wr_strobe got we=%b rd=%b exp 0 0", ram_we, ram_rd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL oor_wr_busy got=%b exp=1", busy); end
        tick();
        tick();
        checks++; if (ack !== 4'b0010 || rdata !== 1'b0) begin errors++; $display("FAIL oor_wr_ack got ack=%b rdata=%b exp ack=0010 rdata=0", ack, rdata); end
        req[1] = 1'b0;
        tick();
        checks++; if (mem[20] !== 1'b0) begin errors++; $display("FAIL oor_wr_dropped got mem20=%b exp=0", mem[20]); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_req(0, 1'b1, 4'd9, 5'd19, 1'b0);
        tick();
        checks++; if (ram_we !== 1'b1 || ram_addr !== 9'd199 || ram_wdata !== 1'b0) begin errors++; $display("FAIL b2b_write got we=%b addr=%0d wd=%b exp we=1 addr=199 wd=0", ram_we, ram_addr, ram_wdata); end
        set_req(2, 1'b0, 4'd9, 5'd19, 1'b0);
        tick();
        checks++; if (ram_rd !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 9'd199) begin errors++; $display("FAIL b2b_read got rd=%b we=%b addr=%0d exp rd=1 we=0 addr=199", ram_rd, ram_we, ram_addr); end
        tick();
        checks++; if (ack !== 4'b0001 || rdata !== 1'b0) begin errors++; $display("FAIL b2b_wr_ack got ack=%b rdata=%b exp ack=0001 rdata=0", ack, rdata); end
        req[0] = 1'b0;
        tick();
        checks++; if (ack !== 4'b0100 || rdata !== 1'b0) begin errors++; $display("FAIL b2b_rd_ack got ack=%b rdata=%b exp ack=0100 rdata=0", ack, rdata); end
        req[2] = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        logic exp_rd;
        logic exp_busy;
        logic [3:0] exp_ack;
        apply_reset();
        set_req(0, 1'b0, 4'd0, 5'd1, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_rd   = (n % 4 == 1);
            exp_busy = (n % 4 == 1) || (n % 4 == 2);
            exp_ack  = (n % 4 == 3) ? 4'b0001 : 4'b0000;
            checks++; if (ram_rd !== exp_rd) begin errors++; $display("FAIL hold_rd cyc=%0d got=%b exp=%b", n, ram_rd, exp_rd); end
            checks++; if (ack !== exp_ack) begin errors++; $display("FAIL hold_ack cyc=%0d got=%b exp=%b", n, ack, exp_ack); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL hold_busy cyc=%0d got=%b exp=%b", n, busy, exp_busy); end
            if (exp_ack[0]) begin
                checks++; if (rdata !== 1'b1) begin errors++; $display("FAIL hold_rdata cyc=%0d got=%b exp=1", n, rdata); end
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        // Pointer returns to 0: stale pointer 2 would pick requester 2 first.
        apply_reset();
        set_req(1, 1'b0, 4'd2, 5'd3, 1'b0);
        tick();
        tick();
        Reset_n = 1'b0;
        req     = '0;
        #1;
        checks++; if ({ack, rdata, busy, ram_rd, ram_we, ram_wdata} !== 9'b0 || ram_addr !== 9'd0) begin errors++; $display("FAIL mid_reset_outs got ack=%b rdata=%b busy=%b rd=%b we=%b addr=%0d exp all 0", ack, rdata, busy, ram_rd, ram_we, ram_addr); end
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if (ack !== 4'b0) begin errors++; $display("FAIL mid_reset_noack cyc=%0d got=%b exp=0000", n, ack); end
        end
        Reset_n = 1'b1;
        set_req(0, 1'b0, 4'd1,  5'd0,  1'b0);
        set_req(2, 1'b0, 4'd14, 5'd19, 1'b0);
        tick();
        checks++; if (ram_addr !== 9'd20) begin errors++; $display("FAIL mid_reset_ptr got addr=%0d exp=20", ram_addr); end

        apply_reset();
        set_req(1, 1'b0, 4'd2, 5'd3, 1'b0);
        tick();
        tick();
        Reset_n = 1'b0;
        req     = '0;
        tick();
        tick();
        checks++; if (ack !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_discard got ack=%b busy=%b exp 0000 0", ack, busy); end
        Reset_n = 1'b1;
        set_req(3, 1'b0, 4'd0, 5'd5, 1'b0);
        tick();
        checks++; if (ram_rd !== 1'b1 || ram_addr !== 9'd5) begin errors++; $display("FAIL mid_reset_req3 got rd=%b addr=%0d exp rd=1 addr=5", ram_rd, ram_addr); end
        tick();
        tick();
        checks++; if (ack !== 4'b1000 || rdata !== 1'b1) begin errors++; $display("FAIL mid_reset_ack3 got ack=%b rdata=%b exp ack=1000 rdata=1", ack, rdata); end
        req[3] = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_all_four();
        test_out_of_range();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
